// File: rtl/seven_segment_driver_pkg.sv
// Shared types and constants for the MM:SS seven-segment display driver.
// Segment patterns are active-low in a..g order (bit 6 = a, bit 0 = g).
package seven_segment_driver_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_0     = 7'b0000001;
  localparam seg_code_t SEG_1     = 7'b1001111;
  localparam seg_code_t SEG_2     = 7'b0010010;
  localparam seg_code_t SEG_3     = 7'b0000110;
  localparam seg_code_t SEG_4     = 7'b1001100;
  localparam seg_code_t SEG_5     = 7'b0100100;
  localparam seg_code_t SEG_6     = 7'b0100000;
  localparam seg_code_t SEG_7     = 7'b0001111;
  localparam seg_code_t SEG_8     = 7'b0000000;
  localparam seg_code_t SEG_9     = 7'b0000100;
  localparam seg_code_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_SEC_ONES = 4'b1110;
  localparam logic [3:0] ANODE_SEC_TENS = 4'b1101;
  localparam logic [3:0] ANODE_MIN_ONES = 4'b1011;
  localparam logic [3:0] ANODE_MIN_TENS = 4'b0111;
  localparam logic [3:0] ANODE_OFF      = 4'b1111;

  typedef enum logic [1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational decimal digit to active-low seven-segment pattern decoder.
// Non-decimal codes 10-15 blank the digit.
import seven_segment_driver_pkg::*;

module bcd_to_seven_segment (
  input  logic [3:0] digit,
  output seg_code_t  segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_driver.sv
// Four-digit multiplexed MM:SS driver for a common-anode display.
// Anode select and cathode pattern are registered together so a digit never shows a neighbour's pattern.
import seven_segment_driver_pkg::*;

module seven_segment_driver #(
  parameter int DIGIT_PERIOD = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] minutes,
  input  logic [6:0] seconds,
  output logic [3:0] anode_signals,
  output seg_code_t  display_out
);

  localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);

  logic [CNT_W-1:0] r_refresh_cnt;
  digit_idx_t       r_digit_idx;

  logic [7:0] w_sec_bcd;
  logic [7:0] w_min_bcd;
  logic [3:0] w_digit;
  logic [3:0] w_anode;
  seg_code_t  w_seg;

  // Saturates at 99, then finds tens by comparing against multiples of ten.
  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [6:0] v;
    logic [3:0] t;
    logic [6:0] o;
    v = (value > 7'd99) ? 7'd99 : value;
    t = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (v >= 7'(10 * k)) t = 4'(k);
    end
    o = v - ({3'b000, t} * 7'd10);
    return {t, o[3:0]};
  endfunction

  assign w_sec_bcd = to_bcd(seconds);
  assign w_min_bcd = to_bcd(minutes);

  always_comb begin
    w_digit = w_sec_bcd[3:0];
    w_anode = ANODE_SEC_ONES;
    case (r_digit_idx)
      DIG_SEC_ONES: begin w_digit = w_sec_bcd[3:0]; w_anode = ANODE_SEC_ONES; end
      DIG_SEC_TENS: begin w_digit = w_sec_bcd[7:4]; w_anode = ANODE_SEC_TENS; end
      DIG_MIN_ONES: begin w_digit = w_min_bcd[3:0]; w_anode = ANODE_MIN_ONES; end
      DIG_MIN_TENS: begin w_digit = w_min_bcd[7:4]; w_anode = ANODE_MIN_TENS; end
      default:      begin w_digit = w_sec_bcd[3:0]; w_anode = ANODE_SEC_ONES; end
    endcase
  end

  bcd_to_seven_segment u_decoder (
    .digit    (w_digit),
    .segments (w_seg)
  );

  // Outputs reflect the digit index held during the edge, so index 0 appears on the first edge out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= DIG_SEC_ONES;
      anode_signals <= ANODE_OFF;
      display_out   <= SEG_BLANK;
    end else begin
      if (r_refresh_cnt == CNT_LAST) begin
        r_refresh_cnt <= '0;
        r_digit_idx   <= digit_idx_t'(r_digit_idx + 2'd1);
      end else begin
        r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
      end
      anode_signals <= w_anode;
      display_out   <= w_seg;
    end
  end

endmodule

// File: tb/tb_seven_segment_driver.sv
// Directed self-checking bench for seven_segment_driver with a 4-cycle digit period.
module tb_seven_segment_driver;

  logic       clock;
  logic       reset;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic [3:0] anode_signals;
  logic [6:0] display_out;

  int checks;
  int failures;

  seven_segment_driver #(.DIGIT_PERIOD(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .minutes       (minutes),
    .seconds       (seconds),
    .anode_signals (anode_signals),
    .display_out   (display_out)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Hand-written segment table, active-low a..g.
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; minutes = 7'd12; seconds = 7'd34;
    @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (anode_signals !== 4'b1111 || display_out !== 7'b1111111) begin
        failures++;
        $display("FAIL reset cycle %0d: anode=%b disp=%b required anode=1111 disp=1111111", c, anode_signals, display_out);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_an [4];
    logic [6:0] exp_ds [4];
    exp_an[0] = 4'b1110; exp_ds[0] = 7'b1001100;
    exp_an[1] = 4'b1101; exp_ds[1] = 7'b0000110;
    exp_an[2] = 4'b1011; exp_ds[2] = 7'b0010010;
    exp_an[3] = 4'b0111; exp_ds[3] = 7'b1001111;
    minutes = 7'd12; seconds = 7'd34;
    reset = 1'b0;
    for (int s = 0; s < 17; s++) begin
      @(negedge clock);
      checks++;
      if (anode_signals !== exp_an[(s / 4) % 4] || display_out !== exp_ds[(s / 4) % 4]) begin
        failures++;
        $display("FAIL scan_order step %0d: anode=%b disp=%b required anode=%b disp=%b",
                 s, anode_signals, display_out, exp_an[(s / 4) % 4], exp_ds[(s / 4) % 4]);
      end
    end
  endtask

  task automatic test_seconds_sweep();
    logic [3:0] seen;
    logic [6:0] want;
    minutes = 7'd0;
    for (int v = 0; v < 60; v++) begin
      seconds = 7'(v);
      seen = 4'b0000;
      for (int c = 0; c < 24 && seen != 4'b1111; c++) begin
        @(negedge clock);
        want = 7'b1111111;
        case (anode_signals)
          4'b1110: begin seen[0] = 1'b1; want = exp_seg(v % 10); end
          4'b1101: begin seen[1] = 1'b1; want = exp_seg(v / 10); end
          4'b1011: begin seen[2] = 1'b1; want = exp_seg(0); end
          4'b0111: begin seen[3] = 1'b1; want = exp_seg(0); end
          default: want = 7'bxxxxxxx;
        endcase
        checks++;
        if (display_out !== want) begin
          failures++;
          $display("FAIL sec_sweep s=%0d anode=%b: disp=%b required %b", v, anode_signals, display_out, want);
        end
      end
      checks++;
      if (seen !== 4'b1111) begin
        failures++;
        $display("FAIL sec_sweep_timeout s=%0d: slots seen=%b required 1111", v, seen);
      end
    end
  endtask

  task automatic test_minutes_sweep();
    logic [3:0] seen;
    logic [6:0] want;
    seconds = 7'd0;
    for (int v = 0; v < 100; v++) begin
      minutes = 7'(v);
      seen = 4'b0000;
      for (int c = 0; c < 24 && seen[3:2] != 2'b11; c++) begin
        @(negedge clock);
        want = display_out;
        if (anode_signals == 4'b1011) begin
          seen[2] = 1'b1;
          want = exp_seg(v % 10);
          checks++;
          if (display_out !== want) begin
            failures++;
            $display("FAIL min_sweep_ones m=%0d: disp=%b required %b", v, display_out, want);
          end
        end else if (anode_signals == 4'b0111) begin
          seen[3] = 1'b1;
          want = exp_seg(v / 10);
          checks++;
          if (display_out !== want) begin
            failures++;
            $display("FAIL min_sweep_tens m=%0d: disp=%b required %b", v, display_out, want);
          end
        end else begin
          seen[1:0] = 2'b00;
        end
      end
      checks++;
      if (seen[3:2] !== 2'b11) begin
        failures++;
        $display("FAIL min_sweep_timeout m=%0d: slots seen=%b required 11", v, seen[3:2]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seen;
    minutes = 7'd0; seconds = 7'd127;
    seen = 2'b00;
    for (int c = 0; c < 24 && seen != 2'b11; c++) begin
      @(negedge clock);
      if (anode_signals == 4'b1110 || anode_signals == 4'b1101) begin
        if (anode_signals == 4'b1110) seen[0] = 1'b1;
        else seen[1] = 1'b1;
        checks++;
        if (display_out !== 7'b0000100) begin
          failures++;
          $display("FAIL saturation anode=%b: disp=%b required 0000100", anode_signals, display_out);
        end
      end
    end
    checks++;
    if (seen !== 2'b11) begin
      failures++;
      $display("FAIL saturation_timeout: slots seen=%b required 11", seen);
    end
  endtask

  task automatic test_mid_digit_change();
    logic [3:0] prev;
    logic       found;
    minutes = 7'd0; seconds = 7'd5;
    found = 1'b0;
    @(negedge clock);
    prev = anode_signals;
    for (int c = 0; c < 24 && !found; c++) begin
      @(negedge clock);
      if (anode_signals == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = anode_signals;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_digit_timeout: slot 1110 entry not seen, last anode=%b", anode_signals);
    end else begin
      checks++;
      if (display_out !== 7'b0100100) begin
        failures++;
        $display("FAIL mid_digit_before: disp=%b required 0100100", display_out);
      end
      seconds = 7'd8;
      @(negedge clock);
      checks++;
      if (anode_signals !== 4'b1110 || display_out !== 7'b0000000) begin
        failures++;
        $display("FAIL mid_digit_after: anode=%b disp=%b required anode=1110 disp=0000000", anode_signals, display_out);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    minutes = 7'd12; seconds = 7'd34;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (anode_signals !== 4'b1111 || display_out !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_mid_scan_blank: anode=%b disp=%b required anode=1111 disp=1111111", anode_signals, display_out);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (c < 4 && (anode_signals !== 4'b1110 || display_out !== 7'b1001100)) begin
        failures++;
        $display("FAIL reset_mid_scan_restart cycle %0d: anode=%b disp=%b required anode=1110 disp=1001100", c, anode_signals, display_out);
      end else if (c == 4 && (anode_signals !== 4'b1101 || display_out !== 7'b0000110)) begin
        failures++;
        $display("FAIL reset_mid_scan_next: anode=%b disp=%b required anode=1101 disp=0000110", anode_signals, display_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; minutes = 7'd0; seconds = 7'd0;
    test_reset();
    test_scan_order();
    test_seconds_sweep();
    test_minutes_sweep();
    test_saturation();
    test_mid_digit_change();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
